// File: rtl/hazard_control.sv
// hazard_control
//   Hazard and stall controller for the 5-stage 32-bit pipeline. Decides
//   each cycle what the F/D, D/X and X/M latches do: load-use stalls,
//   taken-branch squashes, and the multi-cycle mul/div stall (start pulse,
//   wait for ready, forced termination on timeout). Every instruction that
//   reaches execute has operands resolvable by bypassing alone.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   decodeIR, executeIR   instructions in F/D and D/X
//   branch_taken          execute-stage branch/jump resolved taken
//   md_ready              multdiv result valid this cycle
//   freeze_fd, flush_fd   hold PC+F/D / load nop into F/D
//   bubble_dx, hold_dx    load nop into D/X / hold D/X
//   bubble_xm             load nop into X/M
//   ctrl_mult, ctrl_div   one-cycle multdiv start pulses
//   md_result_sel         X/M captures multdiv result
//   md_timeout            one-cycle pulse on forced termination
//   stall_cycles          saturating count of cycles with freeze_fd high
module hazard_control #(
    parameter int MD_TIMEOUT  = 40,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            decodeIR,
    input  logic [31:0]            executeIR,
    input  logic                   branch_taken,
    input  logic                   md_ready,
    output logic                   freeze_fd,
    output logic                   flush_fd,
    output logic                   bubble_dx,
    output logic                   hold_dx,
    output logic                   bubble_xm,
    output logic                   ctrl_mult,
    output logic                   ctrl_div,
    output logic                   md_result_sel,
    output logic                   md_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [5:0]             MD_LAST = 6'(MD_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]             state_q, state_d;
    logic [5:0]             md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [4:0] d_op, d_rd, d_rs, d_rt;
    logic [4:0] x_op, x_rd, x_alu;

    assign d_op  = decodeIR[31:27];
    assign d_rd  = decodeIR[26:22];
    assign d_rs  = decodeIR[21:17];
    assign d_rt  = decodeIR[16:12];
    assign x_op  = executeIR[31:27];
    assign x_rd  = executeIR[26:22];
    assign x_alu = executeIR[6:2];

    logic unused_ir_bits;
    assign unused_ir_bits = ^{decodeIR[11:0], executeIR[21:7], executeIR[1:0]};

    // Register sources actually read in decode. sw data (rd) is deliberately
    // left out: the lw result reaches it through the W->M bypass.
    logic       use_a, use_b;
    logic [4:0] src_a, src_b;

    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        src_a = d_rs;
        src_b = d_rt;
        case (d_op)
            OP_RTYPE: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW: use_a = 1'b1;
            OP_BNE, OP_BLT: begin
                use_a = 1'b1;
                use_b = 1'b1;
                src_b = d_rd;
            end
            OP_JR: begin
                use_a = 1'b1;
                src_a = d_rd;
            end
            default: ;
        endcase
    end

    logic x_is_lw, x_is_mul, x_is_div, load_use;

    assign x_is_lw  = (x_op == OP_LW) && (x_rd != 5'd0);
    assign x_is_mul = (x_op == OP_RTYPE) && (x_alu == ALU_MUL);
    assign x_is_div = (x_op == OP_RTYPE) && (x_alu == ALU_DIV);
    assign load_use = x_is_lw && ((use_a && (src_a == x_rd)) ||
                                  (use_b && (src_b == x_rd)));

    // Priority: mul/div FSM, then taken branch, then load-use. While the FSM
    // starts or is busy, D/X holds a mul/div, so branch/load-use can't apply.
    always_comb begin
        freeze_fd     = 1'b0;
        flush_fd      = 1'b0;
        bubble_dx     = 1'b0;
        hold_dx       = 1'b0;
        bubble_xm     = 1'b0;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        md_result_sel = 1'b0;
        md_timeout    = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;

        if (state_q == S_IDLE && (x_is_mul || x_is_div)) begin
            // start cycle: md_ready is not looked at here
            ctrl_mult = x_is_mul;
            ctrl_div  = x_is_div;
            freeze_fd = 1'b1;
            hold_dx   = 1'b1;
            bubble_xm = 1'b1;
            md_cnt_d  = 6'd0;
            state_d   = S_BUSY;
        end else if (state_q == S_BUSY) begin
            if (md_ready) begin
                md_result_sel = 1'b1;
                state_d       = S_IDLE;
            end else if (md_cnt_q == MD_LAST) begin
                // force-terminate: release the pipe with whatever X/M gets
                md_timeout    = 1'b1;
                md_result_sel = 1'b1;
                state_d       = S_IDLE;
            end else begin
                freeze_fd = 1'b1;
                hold_dx   = 1'b1;
                bubble_xm = 1'b1;
                md_cnt_d  = md_cnt_q + 6'd1;
            end
        end else if (branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
        end else if (load_use) begin
            freeze_fd = 1'b1;
            bubble_dx = 1'b1;
        end

        // outputs are quiet for the whole time reset is held
        if (!reset) begin
            freeze_fd     = 1'b0;
            flush_fd      = 1'b0;
            bubble_dx     = 1'b0;
            hold_dx       = 1'b0;
            bubble_xm     = 1'b0;
            ctrl_mult     = 1'b0;
            ctrl_div      = 1'b0;
            md_result_sel = 1'b0;
            md_timeout    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            md_cnt_q    <= 6'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (freeze_fd && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control. Each step drives the IRs just after a
// rising edge, pushes the expected output vector to a scoreboard queue, and
// pops/compares at the following falling edge. A small saturating model
// tracks the expected stall counter from the expected freeze_fd values.
module tb_hazard_control;

    localparam int CW = 6;  // narrow counter so saturation is reachable

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   decodeIR, executeIR;
    logic          branch_taken, md_ready;
    logic          freeze_fd, flush_fd, bubble_dx, hold_dx, bubble_xm;
    logic          ctrl_mult, ctrl_div, md_result_sel, md_timeout;
    logic [CW-1:0] stall_cycles;

    hazard_control #(.MD_TIMEOUT(40), .STALL_CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .decodeIR(decodeIR), .executeIR(executeIR),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .freeze_fd(freeze_fd), .flush_fd(flush_fd), .bubble_dx(bubble_dx),
        .hold_dx(hold_dx), .bubble_xm(bubble_xm), .ctrl_mult(ctrl_mult),
        .ctrl_div(ctrl_div), .md_result_sel(md_result_sel),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // {freeze, flush, bubble_dx, hold, bubble_xm, mult, div, sel, timeout}
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_LU   = 9'b101000000;
    localparam logic [8:0] E_BR   = 9'b011000000;
    localparam logic [8:0] E_STL  = 9'b100110000;
    localparam logic [8:0] E_MUL  = 9'b100111000;
    localparam logic [8:0] E_DIV  = 9'b100110100;
    localparam logic [8:0] E_RDY  = 9'b000000010;
    localparam logic [8:0] E_TO   = 9'b000000011;

    logic [8:0] outs;
    assign outs = {freeze_fd, flush_fd, bubble_dx, hold_dx, bubble_xm,
                   ctrl_mult, ctrl_div, md_result_sel, md_timeout};

    logic [8:0]    sb[$];
    logic [CW-1:0] exp_stall = '0;
    int            total = 0;
    int            bad = 0;

    function automatic logic [31:0] rt(input logic [4:0] rd, rs, rtt, alu);
        return {5'b00000, rd, rs, rtt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] it(input logic [4:0] op, rd, rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string tag);
        logic [8:0] e;
        e = sb.pop_front();
        total++;
        assert (outs === e) else begin
            bad++;
            $error("FAIL %s outs got=%b exp=%b", tag, outs, e);
        end
        total++;
        assert (stall_cycles === exp_stall) else begin
            bad++;
            $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, exp_stall);
        end
        if (e[8] && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
    endtask

    task automatic step(input logic rst, input logic [31:0] dec, ex,
                        input logic br, rdy, input logic [8:0] e, input string tag);
        @(posedge clock);
        #1;
        reset        = rst;
        decodeIR     = dec;
        executeIR    = ex;
        branch_taken = br;
        md_ready     = rdy;
        sb.push_back(e);
        @(negedge clock);
        check(tag);
    endtask

    logic [31:0] NOP, LW5, LW0, MUL, DIV;

    initial begin
        NOP = 32'd0;
        LW5 = it(5'b01000, 5'd5, 5'd1, 17'd4);
        LW0 = it(5'b01000, 5'd0, 5'd1, 17'd4);
        MUL = rt(5'd1, 5'd2, 5'd3, 5'b00110);
        DIV = rt(5'd1, 5'd2, 5'd3, 5'b00111);

        // reset held low with every input trying to provoke an output
        reset = 1'b0; decodeIR = rt(5'd3, 5'd5, 5'd2, 5'd0); executeIR = MUL;
        branch_taken = 1'b1; md_ready = 1'b1;
        #2;
        sb.push_back(E_NONE);
        check("reset_quiet");

        // load-use and decode source selection
        step(1, rt(5'd3, 5'd5, 5'd2, 5'd0), LW5, 0, 0, E_LU,   "lu_rs");
        step(1, rt(5'd3, 5'd0, 5'd2, 5'd0), LW0, 0, 0, E_NONE, "lw_r0");
        step(1, rt(5'd3, 5'd2, 5'd5, 5'd0), LW5, 0, 0, E_LU,   "lu_rt");
        step(1, it(5'b00101, 5'd3, 5'd4, 17'h05000), LW5, 0, 0, E_NONE, "addi_no_rt");
        step(1, it(5'b00111, 5'd5, 5'd1, 17'd0), LW5, 0, 0, E_NONE, "sw_data");
        step(1, it(5'b00010, 5'd5, 5'd1, 17'd0), LW5, 0, 0, E_LU,   "bne_rd");
        step(1, it(5'b00100, 5'd5, 5'd0, 17'd0), LW5, 0, 0, E_LU,   "jr_rd");
        step(1, it(5'b00001, 5'd5, 5'd5, 17'h05000), LW5, 0, 0, E_NONE, "j_none");
        step(1, rt(5'd3, 5'd5, 5'd2, 5'd0), LW5, 1, 0, E_BR,   "br_over_lu");
        step(1, NOP, NOP, 0, 1, E_NONE, "rdy_idle");

        // mul: ready 17 cycles after start; branch_taken ignored while busy
        step(1, NOP, MUL, 0, 0, E_MUL, "mul_start");
        for (int i = 1; i < 17; i++)
            step(1, NOP, MUL, (i == 5), 0, E_STL, "mul_busy");
        step(1, NOP, MUL, 0, 1, E_RDY, "mul_ready");
        step(1, NOP, NOP, 0, 0, E_NONE, "mul_after");

        // div with no ready: start-cycle ready ignored, timeout on cycle 41
        step(1, NOP, DIV, 0, 1, E_DIV, "div_start");
        for (int i = 1; i < 40; i++)
            step(1, NOP, DIV, 0, 0, E_STL, "div_busy");
        step(1, NOP, DIV, 0, 0, E_TO,   "div_timeout");
        step(1, NOP, NOP, 0, 0, E_NONE, "div_after");

        // push the narrow counter into saturation
        for (int i = 0; i < 4; i++)
            step(1, rt(5'd3, 5'd5, 5'd2, 5'd0), LW5, 0, 0, E_LU, "lu_sat");
        step(1, NOP, NOP, 0, 0, E_NONE, "sat_hold");

        // reset in the middle of a mul/div stall
        step(1, NOP, MUL, 0, 0, E_MUL, "rmul_start");
        step(1, NOP, MUL, 0, 0, E_STL, "rmul_busy");
        step(1, NOP, MUL, 0, 0, E_STL, "rmul_busy");
        #2;
        reset = 1'b0;
        exp_stall = '0;
        #1;
        sb.push_back(E_NONE);
        check("rst_async");
        step(0, NOP, MUL, 0, 0, E_NONE, "rst_held");
        step(1, NOP, MUL, 0, 0, E_MUL,  "rst_restart");
        step(1, NOP, MUL, 0, 0, E_STL,  "rst_busy");
        step(1, NOP, MUL, 0, 1, E_RDY,  "rst_ready");
        step(1, NOP, NOP, 0, 0, E_NONE, "rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
